// File: rtl/textlcd_ctrl_if.sv
// Request port of the textlcd controller: one LCD byte per valid/ready
// handshake. The requester (master) holds rs/data stable until accepted.
interface textlcd_ctrl_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_rs,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rs,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/textlcd_ctrl.sv
// textlcd_ctrl: drives an HD44780-compatible 8-bit character LCD.
// After reset it waits T_POWERUP cycles, writes the fixed init table
// (0x38, 0x38, 0x0C, 0x06, 0x01), then serves one byte request at a time.
// Every byte goes through SETUP -> PULSE (E high) -> HOLD -> EXEC.
// Optional macro TEXTLCD_CMD_FIFO_EN adds a 4-deep request FIFO so the
// requester can queue bytes while the LCD is busy, including during init.
module textlcd_ctrl #(
  parameter int T_POWERUP   = 2000000,
  parameter int T_SETUP     = 4,
  parameter int T_PW        = 25,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 4000,
  parameter int T_EXEC_LONG = 164000,
  parameter int CNT_W       = 24
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  textlcd_ctrl_if.slave        req,
  output logic                 init_done,
  output logic                 busy,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [7:0]           lcd_data
);

  // A zero-length phase would never let the down-counter exit cleanly,
  // so every phase lasts at least one cycle.
  localparam int PWR_E  = (T_POWERUP   < 1) ? 1 : T_POWERUP;
  localparam int SET_E  = (T_SETUP     < 1) ? 1 : T_SETUP;
  localparam int PW_E   = (T_PW        < 1) ? 1 : T_PW;
  localparam int HOLD_E = (T_HOLD      < 1) ? 1 : T_HOLD;
  localparam int EX_E   = (T_EXEC      < 1) ? 1 : T_EXEC;
  localparam int EXL_E  = (T_EXEC_LONG < 1) ? 1 : T_EXEC_LONG;

  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(PWR_E - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SET_E - 1);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(PW_E - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_E - 1);
  localparam logic [CNT_W-1:0] LD_EX    = CNT_W'(EX_E - 1);
  localparam logic [CNT_W-1:0] LD_EXL   = CNT_W'(EXL_E - 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       initIdx_q, initIdx_d;
  logic             initDone_q, initDone_d;
  logic             lcdRs_q, lcdRs_d;
  logic             lcdE_q, lcdE_d;
  logic [7:0]       lcdData_q, lcdData_d;
  logic             timerZero;
  logic             longExec;
  logic             reqAvail;
  logic [8:0]       reqByte;

  function automatic logic [7:0] initByte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0, 3'd1: b = 8'h38;
      3'd2:       b = 8'h0C;
      3'd3:       b = 8'h06;
      default:    b = 8'h01;
    endcase
    return b;
  endfunction

  assign timerZero = (timer_q == '0);
  // Clear and home need the long execution wait; only as commands.
  assign longExec  = !lcdRs_q &&
                     ((lcdData_q == 8'h01) || (lcdData_q == 8'h02) || (lcdData_q == 8'h03));

`ifdef TEXTLCD_CMD_FIFO_EN
  logic [8:0] fifoMem [4];
  logic [1:0] wrPtr_q, rdPtr_q;
  logic [2:0] fifoCnt_q;
  logic       fifoEmpty, fifoFull, fifoPush, fifoPop;

  assign fifoEmpty     = (fifoCnt_q == 3'd0);
  assign fifoFull      = (fifoCnt_q == 3'd4);
  assign fifoPush      = req.req_valid && !fifoFull;
  assign fifoPop       = (state_q == IDLE) && !fifoEmpty;
  assign reqAvail      = !fifoEmpty;
  assign reqByte       = fifoMem[rdPtr_q];
  assign req.req_ready = !fifoFull;
  assign busy          = (state_q != IDLE) || !fifoEmpty;

  // FIFO bookkeeping: pointers and fill level, emptied by reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wrPtr_q   <= 2'd0;
      rdPtr_q   <= 2'd0;
      fifoCnt_q <= 3'd0;
    end else begin
      if (fifoPush) wrPtr_q <= wrPtr_q + 2'd1;
      if (fifoPop)  rdPtr_q <= rdPtr_q + 2'd1;
      fifoCnt_q <= fifoCnt_q + {2'b00, fifoPush} - {2'b00, fifoPop};
    end
  end

  // FIFO storage; contents are don't-care while the level says empty.
  always_ff @(posedge ACLK) begin
    if (fifoPush) fifoMem[wrPtr_q] <= {req.req_rs, req.req_data};
  end
`else
  assign reqAvail      = req.req_valid;
  assign reqByte       = {req.req_rs, req.req_data};
  assign req.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
`endif

  // Next-state logic: phase sequencing, timer reloads and bus updates.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    initIdx_d  = initIdx_q;
    initDone_d = initDone_q;
    lcdRs_d    = lcdRs_q;
    lcdData_d  = lcdData_q;
    case (state_q)
      PWR_WAIT: begin
        // Counts up from the reset value of zero.
        if (timer_q == LD_PWR) begin
          state_d = INIT_LOAD;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      INIT_LOAD: begin
        state_d   = SETUP;
        timer_d   = LD_SETUP;
        lcdRs_d   = 1'b0;
        lcdData_d = initByte(initIdx_q);
      end
      SETUP: begin
        if (timerZero) begin
          state_d = PULSE;
          timer_d = LD_PW;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      PULSE: begin
        if (timerZero) begin
          state_d = HOLD;
          timer_d = LD_HOLD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      HOLD: begin
        if (timerZero) begin
          state_d = EXEC;
          timer_d = longExec ? LD_EXL : LD_EX;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      EXEC: begin
        if (timerZero) begin
          if (!initDone_q) begin
            initIdx_d = initIdx_q + 3'd1;
            if (initIdx_q == 3'd4) begin
              initDone_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = INIT_LOAD;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      IDLE: begin
        if (reqAvail) begin
          state_d   = SETUP;
          timer_d   = LD_SETUP;
          lcdRs_d   = reqByte[8];
          lcdData_d = reqByte[7:0];
        end
      end
      default: begin
        state_d = PWR_WAIT;
        timer_d = '0;
      end
    endcase
    lcdE_d = (state_d == PULSE);
  end

  // State register; reset drops E immediately and restarts power-up.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= PWR_WAIT;
      timer_q    <= '0;
      initIdx_q  <= 3'd0;
      initDone_q <= 1'b0;
      lcdRs_q    <= 1'b0;
      lcdE_q     <= 1'b0;
      lcdData_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      initIdx_q  <= initIdx_d;
      initDone_q <= initDone_d;
      lcdRs_q    <= lcdRs_d;
      lcdE_q     <= lcdE_d;
      lcdData_q  <= lcdData_d;
    end
  end

  assign init_done = initDone_q;
  assign lcd_rs    = lcdRs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcdE_q;
  assign lcd_data  = lcdData_q;

endmodule

// File: tb/tb_textlcd_ctrl.sv
// Testbench for textlcd_ctrl. A timeline model schedules every LCD byte
// (init table plus accepted requests) as a start cycle and derives from it
// what E, RS, DATA, ready, busy and init_done must be in each cycle.
// Works with or without TEXTLCD_CMD_FIFO_EN.
module tb_textlcd_ctrl;

  localparam int TP  = 10;
  localparam int TS  = 3;
  localparam int TPW = 4;
  localparam int TH  = 2;
  localparam int TE  = 6;
  localparam int TEL = 15;
`ifdef TEXTLCD_CMD_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
  localparam int LAT_ADD = 2;
`else
  localparam bit FIFO_ON = 1'b0;
  localparam int LAT_ADD = 1;
`endif

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       init_done, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  textlcd_ctrl_if reqIf();

  textlcd_ctrl #(
    .T_POWERUP(TP), .T_SETUP(TS), .T_PW(TPW), .T_HOLD(TH),
    .T_EXEC(TE), .T_EXEC_LONG(TEL), .CNT_W(24)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req(reqIf),
    .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // ---------------- timeline model ----------------
  typedef struct {
    int         start;
    logic       rs;
    logic [7:0] data;
    int         idleAt;
  } txn_t;

  txn_t       sched[$];
  logic [8:0] mFifo[$];
  int         cnt = 0;
  int         initDoneAt = 0;
  bit         modelOn = 1'b0;
  int         eRiseCnt[$];
  logic [7:0] eData[$];
  int         initDoneRise = -1;
  logic       prevE = 1'b0;
  logic       prevInit = 1'b0;

  function automatic int txnLen(input logic rs, input logic [7:0] d);
    int ex;
    ex = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? TEL : TE;
    return TS + TPW + TH + ex;
  endfunction

  task automatic buildInit();
    logic [7:0] tbl [5];
    int load;
    tbl = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    load = TP;
    sched.delete();
    mFifo.delete();
    eRiseCnt.delete();
    eData.delete();
    prevE = 1'b0;
    prevInit = 1'b0;
    initDoneRise = -1;
    for (int i = 0; i < 5; i++) begin
      txn_t t;
      t.start  = load + 1;
      t.rs     = 1'b0;
      t.data   = tbl[i];
      t.idleAt = t.start + txnLen(1'b0, tbl[i]);
      sched.push_back(t);
      load = t.idleAt;
    end
    initDoneAt = load;
  endtask

  task automatic scheduleTxn(input int st, input logic rs, input logic [7:0] d);
    txn_t t;
    t.start  = st;
    t.rs     = rs;
    t.data   = d;
    t.idleAt = st + txnLen(rs, d);
    sched.push_back(t);
  endtask

  // Per-cycle compare against the model, then advance the model over the edge.
  always @(negedge ACLK) begin : cmpProc
    int          ci;
    bit          idle, space, expE, expRs, expInit, expReady, expBusy;
    logic [7:0]  expData;
    logic [13:0] expV, actV;
    logic [8:0]  h;
    if (modelOn) begin
      ci = -1;
      for (int i = 0; i < sched.size(); i++)
        if (sched[i].start <= cnt) ci = i;
      expInit = (cnt >= initDoneAt);
      idle    = expInit && (cnt >= sched[sched.size()-1].idleAt);
      space   = (mFifo.size() < 4);
      expE    = (ci >= 0) && (cnt >= sched[ci].start + TS) && (cnt < sched[ci].start + TS + TPW);
      expRs   = (ci >= 0) ? sched[ci].rs : 1'b0;
      expData = (ci >= 0) ? sched[ci].data : 8'h00;
      expReady = FIFO_ON ? space : idle;
      expBusy  = FIFO_ON ? (!idle || mFifo.size() > 0) : !idle;
      expV = {expE, expRs, expData, expReady, expBusy, expInit, 1'b0};
      actV = {lcd_e, lcd_rs, lcd_data, reqIf.req_ready, busy, init_done, lcd_rw};
      checkOutput($sformatf("cycle %0d {e,rs,data,ready,busy,init_done,rw}", cnt),
                  32'(actV), 32'(expV));
      if (lcd_e && !prevE) begin
        eRiseCnt.push_back(cnt);
        eData.push_back(lcd_data);
      end
      if (init_done && !prevInit) initDoneRise = cnt;
      prevE    = lcd_e;
      prevInit = init_done;
      if (ARESETN) begin
        if (FIFO_ON) begin
          if (idle && mFifo.size() > 0) begin
            h = mFifo.pop_front();
            scheduleTxn(cnt + 1, h[8], h[7:0]);
          end
          if (reqIf.req_valid && space) mFifo.push_back({reqIf.req_rs, reqIf.req_data});
        end else if (reqIf.req_valid && idle) begin
          scheduleTxn(cnt + 1, reqIf.req_rs, reqIf.req_data);
        end
        cnt++;
      end
    end
    if (!ARESETN) begin
      buildInit();
      cnt = 0;
      modelOn = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  // Present one byte and hold it until the DUT takes it.
  task automatic applyStimulus(input logic rs, input logic [7:0] d);
    int n = 0;
    reqIf.req_valid = 1'b1;
    reqIf.req_rs    = rs;
    reqIf.req_data  = d;
    do begin
      @(negedge ACLK);
      n++;
    end while (!reqIf.req_ready && n < 500);
    if (!reqIf.req_ready) timeoutFail("request accept");
    @(posedge ACLK);
    #1;
    reqIf.req_valid = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (busy && n < bound);
    if (busy) timeoutFail("wait for idle");
    @(posedge ACLK);
    #1;
  endtask

  // Single request from idle: E latency, E width, byte on the bus, turnaround.
  task automatic measureReq(input logic rs, input logic [7:0] d, input int expGap, input string tag);
    int g = 0;
    int eAt = 0;
    int eW = 0;
    logic [8:0] eBus = 9'h0;
    applyStimulus(rs, d);
    do begin
      @(negedge ACLK);
      g++;
      if (lcd_e) begin
        if (eAt == 0) begin
          eAt  = g;
          eBus = {lcd_rs, lcd_data};
        end
        eW++;
      end
    end while (busy && g < 1000);
    checkOutput({tag, " E latency"}, 32'(eAt), 32'(TS + LAT_ADD));
    checkOutput({tag, " E width"}, 32'(eW), 32'(TPW));
    checkOutput({tag, " rs/data at E"}, 32'(eBus), 32'({rs, d}));
    checkOutput({tag, " turnaround"}, 32'(g), 32'(expGap));
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    logic [7:0] initTbl [5];
    int n;
    logic r;
    logic [7:0] d;
    initTbl = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    ARESETN         = 1'b0;
    reqIf.req_valid = 1'b0;
    reqIf.req_rs    = 1'b0;
    reqIf.req_data  = 8'h00;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Power-up and init table.
    waitIdle(400);
    checkOutput("init pulse count", 32'(eRiseCnt.size()), 32'd5);
    checkOutput("first E rise cycle", 32'(eRiseCnt[0]), 32'd14);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("init byte %0d", i), 32'(eData[i]), 32'(initTbl[i]));
    // 10 power-up + 4 x 16 + 25 for the final clear.
    checkOutput("init_done rise cycle", 32'(initDoneRise), 32'd99);

    // Single requests: data, long command, short command.
    measureReq(1'b1, 8'h41, TS + TPW + TH + TE + LAT_ADD, "data 0x41");
    measureReq(1'b0, 8'h01, TS + TPW + TH + TEL + LAT_ADD, "cmd 0x01");
    measureReq(1'b0, 8'h80, TS + TPW + TH + TE + LAT_ADD, "cmd 0x80");

    // Reset while E is high.
    applyStimulus(1'b1, 8'h33);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!lcd_e && n < 100);
    if (!lcd_e) timeoutFail("wait for E pulse");
    @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("lcd_e after reset", 32'(lcd_e), 32'd0);
    checkOutput("init_done after reset", 32'(init_done), 32'd0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Request held throughout the rerun init.
    applyStimulus(1'b1, 8'h5A);
    waitIdle(400);
    checkOutput("init_done rise after reset", 32'(initDoneRise), 32'd99);
    checkOutput("pulses after reset", 32'(eRiseCnt.size()), 32'd6);
    checkOutput("held request byte", 32'(eData[5]), 32'h5A);

    // Back-to-back burst 0x41..0x45.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h41 + 8'(i));
    waitIdle(400);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("burst byte %0d", i), 32'(eData[6 + i]), 32'h41 + 32'(i));

    // Random traffic.
    for (int k = 0; k < 40; k++) begin
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      applyStimulus(r, d);
      repeat ($urandom_range(0, 3)) begin
        @(posedge ACLK);
        #1;
      end
    end
    waitIdle(2000);
    checkOutput("total pulses after reset", 32'(eRiseCnt.size()), 32'd51);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/textlcd_ctrl.md
Name: textlcd_ctrl

Overview:
- Downstream stage of the textlcd AXI4-Lite slave register bank.
- Accepts one LCD byte request at a time over a valid/ready handshake. Each request is a command (RS=0) or a character (RS=1).
- Drives an HD44780-compatible 8-bit character LCD with the required setup, enable-pulse, hold and execution timing.
- Runs a fixed power-on initialisation sequence before it accepts any requests.

Parameters:
- T_POWERUP, 2000000, cycles to wait after reset release before init (20 ms @ 100 MHz).
- T_SETUP, 4, cycles RS/DATA are stable before E rises.
- T_PW, 25, cycles E is held high.
- T_HOLD, 2, cycles RS/DATA are held after E falls.
- T_EXEC, 4000, normal execution wait after the E pulse (40 us).
- T_EXEC_LONG, 164000, execution wait after clear (0x01) or home (0x02/0x03) when RS=0 (1.64 ms).
- CNT_W, 24, timer width; must satisfy 2^CNT_W > every T_* value.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  synchronous active-low reset, sampled on rising ACLK.
- req_valid  in  1  request present.
- req_rs  in  1  0 = command, 1 = data.
- req_data  in  8  byte to write.
- req_ready  out  1  request accepted on the cycle where req_valid & req_ready.
- init_done  out  1  power-on init complete; sticky until reset.
- busy  out  1  high whenever the state is not IDLE, or a FIFO entry is pending.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  tied 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- lcd_data  out  8  LCD data bus.

Behaviour:
- Clock and reset: one clock, ACLK. ARESETN is synchronous and active-low. All state changes on rising ACLK.
- Reset values: state=PWR_WAIT, timer=0, init_idx=0, req_ready=0, init_done=0, busy=1, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_data=0x00.
- States: PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE.
- PWR_WAIT: count T_POWERUP cycles, then go to INIT_LOAD.
- INIT_LOAD: load the init table entry init_idx as an RS=0 byte. Table: 0x38, 0x38, 0x0C, 0x06, 0x01. Go to SETUP.
- SETUP: drive lcd_rs and lcd_data for T_SETUP cycles with lcd_e=0, then go to PULSE.
- PULSE: lcd_e=1 for exactly T_PW cycles, then go to HOLD.
- HOLD: lcd_e=0 and the bus is unchanged for T_HOLD cycles, then go to EXEC.
- EXEC wait length: T_EXEC_LONG if rs=0 and byte is 0x01, 0x02 or 0x03; otherwise T_EXEC.
- EXEC exit during init: init_idx++. If init_idx was 4, set init_done=1 and go to IDLE; otherwise go to INIT_LOAD.
- EXEC exit after a user request: go to IDLE.
- IDLE: req_ready=1. On req_valid, latch req_rs/req_data, deassert req_ready next cycle, go to SETUP.
- Latency: accept -> E rising = T_SETUP+1 cycles. Accept -> next req_ready high = T_SETUP+T_PW+T_HOLD+T_EXEC(+LONG)+1 cycles.
- req_ready is 0 in every state except IDLE; requests outside IDLE are not consumed. The requester holds valid/data stable until accepted.
- lcd_rs and lcd_data change only on entry to SETUP and stay stable through HOLD.
- Timer is a down-counter loaded with T_x-1 on state entry; the state exits when it reaches 0. Any T_x=0 is treated as 1.
- Reset mid-operation: the next edge forces all reset values and drops lcd_e at once. Init reruns from PWR_WAIT.
- Simultaneous req_valid and an EXEC exit: the request is accepted one cycle later, in IDLE.

Optional Feature:
- Macro: TEXTLCD_CMD_FIFO_EN.
- Enabled:
  - A 4-entry, 9-bit (rs+data) FIFO sits between the request port and the FSM.
  - req_ready = !fifo_full, independent of FSM state, including during init.
  - IDLE pops the FIFO head when it is non-empty; pop -> SETUP entry takes 1 cycle.
  - Simultaneous push and pop while full is not allowed, because ready is already low.
  - A push while empty, with a same-cycle IDLE check, pops on the next cycle.
  - busy = (state!=IDLE) | !fifo_empty.
  - Reset empties the FIFO.
- Disabled: no FIFO; handshake exactly as in Behaviour.

Test Plan:
- Reset release with T_POWERUP=10, other T_*=small values -> 5 E pulses carrying 0x38, 0x38, 0x0C, 0x06, 0x01, all with rs=0; init_done rises after the 5th EXEC_LONG; no pulse before cycle 10.
- Write rs=1 data 0x41 after init_done -> lcd_data=0x41 and lcd_rs=1 for T_SETUP before E; E high exactly T_PW cycles; req_ready low until T_EXEC expires.
- Command 0x01 vs command 0x80 -> req_ready returns after T_EXEC_LONG for 0x01 and after T_EXEC for 0x80; measured gap matches the formula.
- ARESETN low during PULSE -> lcd_e=0 next cycle, init_done=0, init sequence restarts.
- req_valid held during init (FIFO off) -> not accepted until the first IDLE cycle; exactly one E pulse per request.
- FIFO on: 5 back-to-back requests 0x41..0x45 -> first 4 accepted, 5th stalls until the first pop, output order preserved.
